cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Memory-side responder for the cache request interface: serves icache fetches and dcache reads, write-backs and flushes against the single-ported RAM.
- One requester is granted at a time. The granted requester's request is forwarded to the RAM, and `iwait`/`dwait` are dropped for exactly the cycle in which the RAM reports ACCESS.
- The dcache has priority and keeps the grant across back-to-back requests, so two-word block transfers are never interleaved with fetches.

Parameters:
- TIMEOUT, 255: cycles a granted request may wait without ACCESS before the error flag is raised.
- ADDR_W, 32: address and data width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  low = `iload` valid this cycle
- iload  out  ADDR_W  fetched instruction
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache word address
- dstore  in  ADDR_W  dcache write data
- dwait  out  1  low = dcache access completes this cycle
- dload  out  ADDR_W  dcache read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- ramload  in  ADDR_W  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- mem_err  out  1  sticky error (RAM ERROR or timeout)
- xfer_cnt  out  16  completed-access counter

Behaviour:
- Reset:
  - state IDLE.
  - `iwait`=1, `dwait`=1.
  - `ramREN`=`ramWEN`=0; `ramaddr`/`ramstore`=0.
  - `mem_err`=0, `xfer_cnt`=0, timeout counter=0.
  - `iload`/`dload` follow `ramload` combinationally at all times.
- States:
  - IDLE: RAM strobes low; both waits high.
  - DGNT: RAM driven from dcache. `ramWEN`=`dWEN`; `ramREN`=`dREN`&~`dWEN`, so write wins if both are high. `ramaddr`=`daddr`, `ramstore`=`dstore`.
  - IGNT: RAM driven from icache. `ramREN`=`iREN`, `ramaddr`=`iaddr`, `ramWEN`=0.
- IDLE transitions (registered):
  - `dREN`|`dWEN` -> DGNT
  - else `iREN` -> IGNT
  - else stay.
  - Minimum one-cycle grant latency: a request arriving in IDLE is not forwarded until the next cycle.
- Completion:
  - In the granted state with `ramstate`==ACCESS and the request still asserted, the granted wait goes low combinationally that same cycle.
  - The other wait stays high.
  - `xfer_cnt` increments, wrapping at 0xFFFF to 0.
  - Timeout counter clears.
- After a D completion:
  - `dREN`|`dWEN` still high -> stay DGNT; this is the block lock for consecutive words, write-back-then-load and flush.
  - else `iREN` -> IGNT
  - else IDLE.
- After an I completion:
  - dcache pending -> DGNT
  - else `iREN` -> IGNT
  - else IDLE.
  - dcache is never starved by fetches. icache may wait for an entire dcache flush; this is accepted.
- Withdrawal: if the granted requester deasserts its request before ACCESS, its strobes drop combinationally, and next state is chosen as from IDLE. No completion is counted.
- BUSY/FREE: hold the request and the state. The timeout counter increments each cycle while granted without ACCESS.
- Timeout: when the counter reaches TIMEOUT, `mem_err` is set. The counter saturates and the grant is held; the error does not release the requester.
- ERROR: `ramstate`==ERROR while granted sets `mem_err`. The wait stays high and the request keeps being driven (retry).
- `mem_err` clears only on reset.
- Mid-operation reset: all outputs return to reset values immediately (asynchronous); the in-flight access is abandoned.

Test Plan:
1. Single fetch:
   - Stimulus: `iREN`=1, `iaddr`=0x40; RAM returns BUSY for 2 cycles, then ACCESS with `ramload`=0xDEADBEEF.
   - Required: `ramREN` high from cycle 1; `iwait` low only in the ACCESS cycle with `iload`=0xDEADBEEF; `xfer_cnt`=1.
2. Simultaneous requests:
   - Stimulus: `iREN` and `dREN` rise together.
   - Required: DGNT first; the dcache completes; then IGNT; `ramaddr` switches from `daddr` to `iaddr`; `xfer_cnt`=2.
3. Block lock:
   - Stimulus: dcache writes 0x100/0x104 back-to-back with `iREN` held high; `dstore` values 0x11 and 0x22.
   - Required: `ramWEN` carries 0x11 then 0x22 with no IGNT between them; the icache is served only afterwards.
4. Read/write conflict and withdrawal:
   - Stimulus: `dREN`=`dWEN`=1.
   - Required: `ramWEN`=1, `ramREN`=0.
   - Stimulus: then drop `dWEN` during BUSY.
   - Required: strobes drop and the state returns via the IDLE rule; `xfer_cnt` unchanged.
5. Timeout and ERROR:
   - Stimulus: TIMEOUT=4, RAM stuck at BUSY.
   - Required: `mem_err`=1 after 4 granted cycles; `dwait` stays 1.
   - Stimulus: separately, drive `ramstate`=3.
   - Required: `mem_err` sets and stays sticky until `nRST`.
6. Reset mid-access:
   - Stimulus: assert `nRST`=0 during a BUSY dcache access.
   - Required: strobes, `mem_err` and `xfer_cnt` clear immediately; IDLE after release.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - single-ported RAM arbiter for icache/dcache requests
// dcache has priority and keeps the grant while it keeps requesting.
module cache_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err,
  output logic [15:0]       xfer_cnt
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;

  state_t        state, state_next;
  logic [TW-1:0] tmo_cnt;
  logic          dreq;
  logic          active;
  logic          done;

  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  always_comb begin
    state_next = state;
    active     = 1'b0;
    done       = 1'b0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    case (state)
      DGNT: begin
        active   = dreq;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      IGNT: begin
        active  = iREN;
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      default: ;
    endcase
    done = active && (ramstate == RS_ACCESS);
    if (done && state == DGNT) dwait = 1'b0;
    if (done && state == IGNT) iwait = 1'b0;
    // Completion, withdrawal and idle all re-arbitrate with the same priority.
    if (!active || done) begin
      if (dreq)      state_next = DGNT;
      else if (iREN) state_next = IGNT;
      else           state_next = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_cnt  <= '0;
      mem_err  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (done) xfer_cnt <= xfer_cnt + 16'd1;
      if (active && !done) begin
        if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_cnt >= TMO_LAST) mem_err <= 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (state != IDLE && ramstate == RS_ERROR) mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed and randomized bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [15:0] xfer_cnt;

  cache_mem_arbiter #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err), .xfer_cnt(xfer_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM (0 nobody, 1 dcache, 2 icache),
  // how long the owner has been waiting, sticky error, completed accesses.
  int          m_owner = 0;
  int          m_wc = 0;
  logic        m_err = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        m_dreq, m_active, m_done;
  logic        e_iwait, e_dwait, e_ren, e_wen;
  logic [31:0] e_addr, e_store;

  always_comb begin
    m_dreq   = dREN | dWEN;
    m_active = (m_owner == 1 && m_dreq) || (m_owner == 2 && iREN);
    m_done   = m_active && ramstate == 2'd2;
    e_dwait  = !(m_done && m_owner == 1);
    e_iwait  = !(m_done && m_owner == 2);
    e_wen    = (m_owner == 1) && dWEN;
    e_ren    = (m_owner == 1) ? (dREN && !dWEN) : (m_owner == 2) ? iREN : 1'b0;
    e_addr   = (m_owner == 1) ? daddr : (m_owner == 2) ? iaddr : 32'd0;
    e_store  = (m_owner == 1) ? dstore : 32'd0;
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_owner <= 0;
      m_wc    <= 0;
      m_err   <= 1'b0;
      m_cnt   <= '0;
    end else begin
      if (m_done) m_cnt <= m_cnt + 16'd1;
      if (m_active && !m_done) begin
        m_wc <= m_wc + 1;
        if (m_wc + 1 >= TMO) m_err <= 1'b1;
      end else begin
        m_wc <= 0;
      end
      if (m_owner != 0 && ramstate == 2'd3) m_err <= 1'b1;
      if (!m_active || m_done) m_owner <= m_dreq ? 1 : (iREN ? 2 : 0);
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("iwait", {31'd0, iwait}, {31'd0, e_iwait});
      chk("dwait", {31'd0, dwait}, {31'd0, e_dwait});
      chk("ramREN", {31'd0, ramREN}, {31'd0, e_ren});
      chk("ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
      chk("ramaddr", ramaddr, e_addr);
      chk("ramstore", ramstore, e_store);
      chk("iload", iload, ramload);
      chk("dload", dload, ramload);
      chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
      chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, m_cnt});
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic look;
    @(negedge CLK);
  endtask

  task automatic idle_inputs;
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0; ramstate = 2'd0;
  endtask

  task automatic do_reset;
    nRST = 1'b0;
    idle_inputs();
    #1;
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    tick();
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    #1;
    chk_on = 1'b1;
    do_reset();

    // 1: single fetch with two BUSY cycles
    iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
    look(); chk("t1_latency", {31'd0, ramREN}, 32'd0);
    tick();
    look(); chk("t1_ren", {31'd0, ramREN}, 32'd1); chk("t1_addr", ramaddr, 32'h40);
    tick();
    look(); chk("t1_busy_wait", {31'd0, iwait}, 32'd1);
    tick(); ramstate = 2'd2; ramload = 32'hDEADBEEF;
    look(); chk("t1_iwait", {31'd0, iwait}, 32'd0); chk("t1_iload", iload, 32'hDEADBEEF);
    tick(); iREN = 0; ramstate = 2'd0;
    look(); chk("t1_cnt", {16'd0, xfer_cnt}, 32'd1); chk("t1_iwait_hi", {31'd0, iwait}, 32'd1);
    tick();
    do_reset();

    // 2: simultaneous requests, dcache first
    iREN = 1; dREN = 1; daddr = 32'h200; iaddr = 32'h300; ramstate = 2'd2;
    look(); chk("t2_idle_dwait", {31'd0, dwait}, 32'd1);
    tick();
    look(); chk("t2_daddr", ramaddr, 32'h200); chk("t2_dwait", {31'd0, dwait}, 32'd0);
    chk("t2_iwait", {31'd0, iwait}, 32'd1);
    tick(); dREN = 0;
    look(); chk("t2_withdraw", {31'd0, ramREN}, 32'd0);
    tick();
    look(); chk("t2_iaddr", ramaddr, 32'h300); chk("t2_iwait_lo", {31'd0, iwait}, 32'd0);
    tick(); iREN = 0; ramstate = 2'd0;
    look(); chk("t2_cnt", {16'd0, xfer_cnt}, 32'd2);
    tick();
    do_reset();

    // 3: two-word write-back holds the grant against a waiting fetch
    dWEN = 1; daddr = 32'h100; dstore = 32'h11; iREN = 1; iaddr = 32'h80; ramstate = 2'd2;
    tick();
    look(); chk("t3_w0_addr", ramaddr, 32'h100); chk("t3_w0_data", ramstore, 32'h11);
    chk("t3_w0_wen", {31'd0, ramWEN}, 32'd1);
    tick(); daddr = 32'h104; dstore = 32'h22;
    look(); chk("t3_w1_addr", ramaddr, 32'h104); chk("t3_w1_data", ramstore, 32'h22);
    chk("t3_w1_iwait", {31'd0, iwait}, 32'd1);
    tick(); dWEN = 0;
    look(); chk("t3_release", {31'd0, ramWEN}, 32'd0);
    tick();
    look(); chk("t3_fetch", ramaddr, 32'h80); chk("t3_fetch_iwait", {31'd0, iwait}, 32'd0);
    tick(); iREN = 0; ramstate = 2'd0;
    look(); chk("t3_cnt", {16'd0, xfer_cnt}, 32'd3);
    tick();
    do_reset();

    // 4: read/write conflict, then withdrawal
    dREN = 1; dWEN = 1; daddr = 32'h300; ramstate = 2'd1;
    tick();
    look(); chk("t4_strobes", {30'd0, ramREN, ramWEN}, 32'd1);
    tick(); dWEN = 0;
    look(); chk("t4_to_read", {30'd0, ramREN, ramWEN}, 32'd2);
    tick(); dREN = 0; iREN = 1; iaddr = 32'h44;
    look(); chk("t4_dropped", {30'd0, ramREN, ramWEN}, 32'd0);
    tick();
    look(); chk("t4_regrant", ramaddr, 32'h44); chk("t4_cnt", {16'd0, xfer_cnt}, 32'd0);
    tick();
    do_reset();

    // 5: timeout after TMO granted cycles, then RAM ERROR
    dREN = 1; ramstate = 2'd1;
    tick();
    for (int g = 1; g <= TMO; g++) begin
      look();
      if (g == TMO) chk("t5_err_early", {31'd0, mem_err}, 32'd0);
      tick();
    end
    look(); chk("t5_timeout", {31'd0, mem_err}, 32'd1); chk("t5_dwait", {31'd0, dwait}, 32'd1);
    tick();
    do_reset();
    dREN = 1; ramstate = 2'd3;
    tick();
    look(); chk("t5_err_pre", {31'd0, mem_err}, 32'd0);
    tick();
    look(); chk("t5_err", {31'd0, mem_err}, 32'd1); chk("t5_retry", {31'd0, ramREN}, 32'd1);
    tick(); ramstate = 2'd2;
    look(); chk("t5_done", {31'd0, dwait}, 32'd0);
    tick(); dREN = 0; ramstate = 2'd0;
    tick();
    look(); chk("t5_sticky", {31'd0, mem_err}, 32'd1);
    tick();
    do_reset();
    look(); chk("t5_cleared", {31'd0, mem_err}, 32'd0);
    tick();

    // 6: asynchronous reset during a BUSY write
    dWEN = 1; daddr = 32'h500; ramstate = 2'd3;
    tick();
    tick(); ramstate = 2'd2;
    tick(); ramstate = 2'd1;
    look(); chk("t6_pre_wen", {31'd0, ramWEN}, 32'd1); chk("t6_pre_cnt", {16'd0, xfer_cnt}, 32'd1);
    chk("t6_pre_err", {31'd0, mem_err}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t6_wen", {31'd0, ramWEN}, 32'd0); chk("t6_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("t6_err", {31'd0, mem_err}, 32'd0);
    tick(); nRST = 1'b1;
    look(); chk("t6_idle", {31'd0, ramWEN}, 32'd0);
    tick();
    look(); chk("t6_regrant", {31'd0, ramWEN}, 32'd1);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      if (c % 250 == 0) do_reset();
      r = $urandom_range(0, 99);
      ramstate = (r < 40) ? 2'd2 : (r < 70) ? 2'd1 : (r < 97) ? 2'd0 : 2'd3;
      if ($urandom_range(0, 9) < 3) begin
        dREN = $urandom_range(0, 1) == 1;
        dWEN = $urandom_range(0, 3) == 0;
        iREN = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 3) == 0) begin
        iaddr  = $urandom;
        daddr  = $urandom;
        dstore = $urandom;
      end
      ramload = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
